// File: rtl/buzzer_sched.sv
// Single-piezo tone scheduler for the keypad lock.
// Fixed priority alarm > fail > ok > key, with preemption and pending replay.
module buzzer_sched #(
  parameter int unsigned KEY_HALF  = 50000,
  parameter int unsigned KEY_LEN   = 10000000,
  parameter int unsigned OK_HALF   = 25000,
  parameter int unsigned OK_LEN    = 30000000,
  parameter int unsigned FAIL_HALF = 100000,
  parameter int unsigned FAIL_SEG  = 5000000,
  parameter int unsigned ALM_HALF  = 12500,
  parameter int unsigned ALM_SEG   = 25000000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       req_key,
  input  logic       req_ok,
  input  logic       req_fail,
  input  logic       alarm_en,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] tone_id,
  output logic       done
);

  localparam logic IDLE = 1'b0;
  localparam logic PLAY = 1'b1;

  localparam logic [1:0] T_KEY  = 2'd0;
  localparam logic [1:0] T_OK   = 2'd1;
  localparam logic [1:0] T_FAIL = 2'd2;
  localparam logic [1:0] T_ALM  = 2'd3;

  localparam logic [31:0] KEY_H = 32'(KEY_HALF - 1);
  localparam logic [31:0] OK_H  = 32'(OK_HALF - 1);
  localparam logic [31:0] FL_H  = 32'(FAIL_HALF - 1);
  localparam logic [31:0] AL_H  = 32'(ALM_HALF - 1);
  localparam logic [31:0] KEY_E = 32'(KEY_LEN - 1);
  localparam logic [31:0] OK_E  = 32'(OK_LEN - 1);
  localparam logic [31:0] FL_E  = 32'(3 * FAIL_SEG - 1);
  localparam logic [31:0] AL_E  = 32'(2 * ALM_SEG - 1);
  localparam logic [31:0] FL_S1 = 32'(FAIL_SEG);
  localparam logic [31:0] FL_S2 = 32'(2 * FAIL_SEG);
  localparam logic [31:0] AL_S1 = 32'(ALM_SEG);

  logic        state;
  logic [1:0]  tone;
  logic [31:0] dur_cnt;
  logic [31:0] half_cnt;
  logic        tbit;
  logic        ok_pend;
  logic        fail_pend;

  logic        sel_any;
  logic [1:0]  sel_id;
  logic        preempt;
  logic        start;
  logic [31:0] half_lim;
  logic [31:0] end_cnt;
  logic        gate;
  logic        fin;
  logic        alm_stop;

  // Highest-priority request present this cycle (pending flags included).
  always_comb begin
    sel_any = alarm_en | req_fail | fail_pend
            | req_ok | ok_pend | req_key;
    sel_id = T_KEY;
    if (alarm_en)
      sel_id = T_ALM;
    else if (req_fail | fail_pend)
      sel_id = T_FAIL;
    else if (req_ok | ok_pend)
      sel_id = T_OK;
  end

  // Per-tone half period, terminal count and on/off gating.
  always_comb begin
    half_lim = KEY_H;
    end_cnt  = KEY_E;
    gate     = 1'b1;
    unique case (tone)
      T_KEY: begin
        half_lim = KEY_H;
        end_cnt  = KEY_E;
      end
      T_OK: begin
        half_lim = OK_H;
        end_cnt  = OK_E;
      end
      T_FAIL: begin
        half_lim = FL_H;
        end_cnt  = FL_E;
        gate     = ~((dur_cnt >= FL_S1) && (dur_cnt < FL_S2));
      end
      T_ALM: begin
        half_lim = AL_H;
        end_cnt  = AL_E;
        gate     = dur_cnt < AL_S1;
      end
    endcase
  end

  assign preempt  = (state == PLAY) & sel_any & (sel_id > tone);
  assign start    = ((state == IDLE) & sel_any) | preempt;
  assign fin      = (state == PLAY) & (tone != T_ALM)
                  & (dur_cnt == end_cnt);
  assign alm_stop = (state == PLAY) & (tone == T_ALM) & ~alarm_en;

  assign busy    = state;
  assign tone_id = tone;
  assign done    = fin & ~preempt;
  assign buzzer  = state & tbit & gate & ~mute;

  // Tone sequencing: start/preempt, natural end, alarm stop, count.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      tone     <= T_KEY;
      dur_cnt  <= '0;
      half_cnt <= '0;
      tbit     <= 1'b0;
    end else if (start) begin
      state    <= PLAY;
      tone     <= sel_id;
      dur_cnt  <= '0;
      half_cnt <= '0;
      tbit     <= 1'b1;
    end else if (fin | alm_stop) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      half_cnt <= '0;
      tbit     <= 1'b0;
    end else if (state == PLAY) begin
      if (half_cnt == half_lim) begin
        half_cnt <= '0;
        tbit     <= ~tbit;
      end else begin
        half_cnt <= half_cnt + 32'd1;
      end
      if (tone == T_ALM && dur_cnt == end_cnt)
        dur_cnt <= '0;
      else
        dur_cnt <= dur_cnt + 32'd1;
    end
  end

  // Ok/fail requests not started now are remembered for later.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ok_pend   <= 1'b0;
      fail_pend <= 1'b0;
    end else begin
      ok_pend   <= (ok_pend | req_ok)
                 & ~(start & (sel_id == T_OK));
      fail_pend <= (fail_pend | req_fail)
                 & ~(start & (sel_id == T_FAIL));
    end
  end

endmodule

// File: tb/tb_buzzer_sched.sv
// Self-checking bench for buzzer_sched.
// Elapsed-time reference model plus directed and random scenarios.
module tb_buzzer_sched;

  logic       clk = 1'b0;
  logic       RST;
  logic       req_key;
  logic       req_ok;
  logic       req_fail;
  logic       alarm_en;
  logic       mute;
  logic       buzzer;
  logic       busy;
  logic [1:0] tone_id;
  logic       done;

  int checks = 0;
  int errors = 0;

  bit m_play;
  int m_tone;
  int m_t;
  bit m_okp;
  bit m_flp;

  int e_hi;
  bit e_pre;
  bit e_buz;
  bit e_busy;
  bit e_done;
  logic [4:0] e_vec;

  always #5 clk = ~clk;

  buzzer_sched #(
    .KEY_HALF(2), .KEY_LEN(20),
    .OK_HALF(1), .OK_LEN(12),
    .FAIL_HALF(4), .FAIL_SEG(8),
    .ALM_HALF(1), .ALM_SEG(6)
  ) dut (
    .clk(clk), .RST(RST),
    .req_key(req_key), .req_ok(req_ok),
    .req_fail(req_fail), .alarm_en(alarm_en),
    .mute(mute), .buzzer(buzzer), .busy(busy),
    .tone_id(tone_id), .done(done)
  );

  function automatic int tlen(input int tn);
    case (tn)
      0: return 20;
      1: return 12;
      2: return 24;
      default: return 0;
    endcase
  endfunction

  function automatic int thalf(input int tn);
    case (tn)
      0: return 2;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit tgate(input int tn, input int t);
    if (tn == 2) return !(t >= 8 && t < 16);
    if (tn == 3) return ((t / 6) % 2) == 0;
    return 1'b1;
  endfunction

  function automatic void model_eval();
    if (alarm_en) e_hi = 3;
    else if (req_fail || m_flp) e_hi = 2;
    else if (req_ok || m_okp) e_hi = 1;
    else if (req_key) e_hi = 0;
    else e_hi = -1;
    e_pre  = m_play && (e_hi > m_tone);
    e_busy = m_play;
    e_buz  = m_play && (((m_t / thalf(m_tone)) % 2) == 0)
             && tgate(m_tone, m_t) && !mute;
    e_done = m_play && m_tone != 3
             && m_t == tlen(m_tone) - 1 && !e_pre;
    e_vec  = {e_buz, e_busy, e_done,
              e_busy ? 2'(m_tone) : 2'd0};
  endfunction

  function automatic void model_adv();
    bit st;
    st = (!m_play && e_hi >= 0) || e_pre;
    if (req_ok) m_okp = 1'b1;
    if (req_fail) m_flp = 1'b1;
    if (st) begin
      m_play = 1'b1;
      m_tone = e_hi;
      m_t = 0;
      if (e_hi == 1) m_okp = 1'b0;
      if (e_hi == 2) m_flp = 1'b0;
    end else if (e_done || (m_play && m_tone == 3 && !alarm_en)) begin
      m_play = 1'b0;
    end else if (m_play) begin
      m_t++;
    end
  endfunction

  function automatic void model_reset();
    m_play = 1'b0;
    m_tone = 0;
    m_t = 0;
    m_okp = 1'b0;
    m_flp = 1'b0;
  endfunction

  task automatic cyc(input logic k, input logic o, input logic f,
                     input logic a, input logic m);
    @(posedge clk);
    model_adv();
    #1;
    req_key = k;
    req_ok = o;
    req_fail = f;
    alarm_en = a;
    mute = m;
    @(negedge clk);
    model_eval();
  endtask

  task automatic release_reset();
    req_key = 0; req_ok = 0; req_fail = 0;
    alarm_en = 0; mute = 0;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    model_reset();
    model_eval();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req_key = 0; req_ok = 0; req_fail = 0;
    alarm_en = 0; mute = 0;
    #2;
    checks++;
    if (buzzer !== 1'b0) begin
      errors++;
      $display("FAIL reset_buzzer got %b exp 0", buzzer);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    checks++;
    if (tone_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_tone got %0d exp 0", tone_id);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b exp 0", done);
    end
    release_reset();
  endtask

  task automatic test_key();
    int nb = 0;
    int nd = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(i == 0, 0, 0, 0, 0);
      nb += busy;
      if (done) begin
        nd++;
        checks++;
        if (nb !== 20) begin
          errors++;
          $display("FAIL key_done_pos got %0d exp 20", nb);
        end
      end
      checks++;
      if ({buzzer, busy, done, busy ? tone_id : 2'd0} !== e_vec) begin
        errors++;
        $display("FAIL key cyc %0d got %b exp %b", i,
                 {buzzer, busy, done, busy ? tone_id : 2'd0}, e_vec);
      end
    end
    checks++;
    if (nb !== 20 || nd !== 1) begin
      errors++;
      $display("FAIL key_len got busy %0d done %0d exp 20 1", nb, nd);
    end
  endtask

  task automatic test_fail();
    int nb = 0;
    int nd = 0;
    for (int i = 0; i < 28; i++) begin
      cyc(0, 0, i == 0, 0, 0);
      nb += busy;
      nd += done;
      checks++;
      if ({buzzer, busy, done, busy ? tone_id : 2'd0} !== e_vec) begin
        errors++;
        $display("FAIL fail_pat cyc %0d got %b exp %b", i,
                 {buzzer, busy, done, busy ? tone_id : 2'd0}, e_vec);
      end
    end
    checks++;
    if (nb !== 24 || nd !== 1) begin
      errors++;
      $display("FAIL fail_len got busy %0d done %0d exp 24 1", nb, nd);
    end
  endtask

  task automatic test_preempt();
    int nb = 0;
    int nd = 0;
    int nok = 0;
    for (int i = 0; i < 34; i++) begin
      cyc(0, i == 0, i == 5, 0, 0);
      nb += busy;
      nd += done;
      if (busy && tone_id == 2'd1) nok++;
      checks++;
      if ({buzzer, busy, done, busy ? tone_id : 2'd0} !== e_vec) begin
        errors++;
        $display("FAIL preempt cyc %0d got %b exp %b", i,
                 {buzzer, busy, done, busy ? tone_id : 2'd0}, e_vec);
      end
    end
    checks++;
    if (nb !== 29 || nd !== 1 || nok !== 5) begin
      errors++;
      $display("FAIL preempt_tot got busy %0d done %0d ok %0d exp 29 1 5",
               nb, nd, nok);
    end
  endtask

  task automatic test_pending();
    int nb = 0;
    int nd = 0;
    for (int i = 0; i < 42; i++) begin
      cyc(i == 10, i == 3, i == 0, 0, 0);
      nb += busy;
      nd += done;
      if (i == 25) begin
        checks++;
        if (busy !== 1'b0 || buzzer !== 1'b0) begin
          errors++;
          $display("FAIL pend_gap got busy %b buz %b exp 0 0",
                   busy, buzzer);
        end
      end
      checks++;
      if ({buzzer, busy, done, busy ? tone_id : 2'd0} !== e_vec) begin
        errors++;
        $display("FAIL pending cyc %0d got %b exp %b", i,
                 {buzzer, busy, done, busy ? tone_id : 2'd0}, e_vec);
      end
    end
    checks++;
    if (nb !== 36 || nd !== 2) begin
      errors++;
      $display("FAIL pend_tot got busy %0d done %0d exp 36 2", nb, nd);
    end
  endtask

  task automatic test_alarm_mute();
    int nd = 0;
    logic a;
    logic m;
    for (int i = 0; i < 40; i++) begin
      a = (i >= 3 && i < 33);
      m = (i >= 10 && i < 15);
      cyc(i == 0, 0, 0, a, m);
      nd += done;
      if (m) begin
        checks++;
        if (buzzer !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL mute got buz %b busy %b exp 0 1", buzzer, busy);
        end
      end
      checks++;
      if ({buzzer, busy, done, busy ? tone_id : 2'd0} !== e_vec) begin
        errors++;
        $display("FAIL alarm cyc %0d got %b exp %b", i,
                 {buzzer, busy, done, busy ? tone_id : 2'd0}, e_vec);
      end
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL alarm_done got %0d exp 0", nd);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      cyc(0, i == 0 || i == 3, 0, 0, 0);
      checks++;
      if ({buzzer, busy, done, busy ? tone_id : 2'd0} !== e_vec) begin
        errors++;
        $display("FAIL rmid_pre cyc %0d got %b exp %b", i,
                 {buzzer, busy, done, busy ? tone_id : 2'd0}, e_vec);
      end
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({buzzer, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_async got %b exp 000", {buzzer, busy, done});
    end
    release_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (busy !== 1'b0 || buzzer !== 1'b0) begin
        errors++;
        $display("FAIL rmid_quiet cyc %0d got busy %b buz %b exp 0 0",
                 i, busy, buzzer);
      end
    end
  endtask

  task automatic test_random();
    logic a = 0;
    logic m = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) a = ~a;
      if ($urandom_range(0, 15) == 0) m = ~m;
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 39) == 0, a, m);
      checks++;
      if ({buzzer, busy, done, busy ? tone_id : 2'd0} !== e_vec) begin
        errors++;
        $display("FAIL random cyc %0d got %b exp %b", i,
                 {buzzer, busy, done, busy ? tone_id : 2'd0}, e_vec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_key();
    test_fail();
    test_preempt();
    test_pending();
    test_alarm_mute();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
